// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op encodings, FSM states, XLEN.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SLL    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_MUL    = 4'b1000;
    localparam logic [3:0] ALU_MULH   = 4'b1001;
    localparam logic [3:0] ALU_MULHSU = 4'b1010;
    localparam logic [3:0] ALU_MULHU  = 4'b1011;
    localparam logic [3:0] ALU_DIV    = 4'b1100;
    localparam logic [3:0] ALU_DIVU   = 4'b1101;
    localparam logic [3:0] ALU_REM    = 4'b1110;
    localparam logic [3:0] ALU_REMU   = 4'b1111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative RV32M engine: shift-add multiplier / restoring divider on magnitudes.
// Fixed WIDTH+1 edges from start to done pulse; start is only honoured when idle.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               sa_q, sa_d;
    logic               bz_q, bz_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               done_q, done_d;

    logic               a_sgn, b_sgn, sa, sb;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, rem_new;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    // Divides (op[2]) are signed when op[0]=0; MULH/MULHSU take a signed rs1, only MULH a signed rs2.
    assign a_sgn = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
    assign b_sgn = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
    assign sa    = a_sgn & a_i[WIDTH-1];
    assign sb    = b_sgn & b_i[WIDTH-1];

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_diff  = div_shift[WIDTH-1:0] - b_q;
    assign rem_new   = div_ge ? div_diff : div_shift[WIDTH-1:0];

    assign prod = neg_q ? -acc_q : acc_q;
    assign quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        a_d     = a_q;
        op_d    = op_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        bz_d    = bz_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, (sa ? -a_i : a_i)};
                    b_d     = sb ? -b_i : b_i;
                    a_d     = a_i;
                    op_d    = op_i;
                    neg_d   = sa ^ sb;
                    sa_d    = sa;
                    bz_d    = (b_i == '0);
                    ovf_d   = a_sgn && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
                end
            end
            BUSY: begin
                acc_d = op_q[2] ? {rem_new, acc_q[WIDTH-2:0], div_ge}
                                : {mul_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                case ({1'b1, op_q})
                    ALU_MUL:            res_d = prod[WIDTH-1:0];
                    ALU_MULH, ALU_MULHSU,
                    ALU_MULHU:          res_d = prod[2*WIDTH-1:WIDTH];
                    ALU_DIV, ALU_DIVU:  res_d = bz_q  ? '1 :
                                                ovf_q ? {1'b1, {(WIDTH-1){1'b0}}} : quot;
                    default:            res_d = bz_q  ? a_q :
                                                ovf_q ? '0 : rem;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            a_q     <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            bz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            a_q     <= a_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            bz_q    <= bz_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign done_o   = done_q;
    assign result_o = res_q;

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: base ops registered at accept (done next cycle), M ops via seq_muldiv.
// M ops: done WIDTH+2 edges after accept; ready_o low while busy, requester holds valid_i.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       alu_op_i,
    input  logic             flag_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic             accept, md_start, md_done;
    logic [WIDTH-1:0] md_res, base_res;
    logic [4:0]       shamt;

    assign ready_o  = (state_q == IDLE);
    assign accept   = valid_i && ready_o;
    assign md_start = accept && alu_op_i[3];
    assign shamt    = b_i[4:0];

    always_comb begin
        base_res = '0;
        case ({1'b0, alu_op_i[2:0]})
            ALU_ADD:  base_res = flag_i ? (a_i - b_i) : (a_i + b_i);
            ALU_SLL:  base_res = a_i << shamt;
            ALU_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: base_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:  base_res = a_i ^ b_i;
            ALU_SRL:  base_res = flag_i ? WIDTH'($signed(a_i) >>> shamt) : (a_i >> shamt);
            ALU_OR:   base_res = a_i | b_i;
            ALU_AND:  base_res = a_i & b_i;
            default:  base_res = '0;
        endcase
    end

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (md_start),
        .op_i     (alu_op_i[2:0]),
        .a_i      (a_i),
        .b_i      (b_i),
        .done_o   (md_done),
        .result_o (md_res)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (alu_op_i[3]) begin
                        state_d = BUSY;
                    end else begin
                        result_d = base_res;
                        done_d   = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d  = IDLE;
                    result_d = md_res;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle: results, latency, ready_o, done pulse width, reset abort.
module tb_alu_multicycle;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  alu_op_i;
    logic        flag_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] result_o;
    logic        done_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .alu_op_i (alu_op_i),
        .flag_i   (flag_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .result_o (result_o),
        .done_o   (done_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issue one request; valid_i stays high (with scrambled operands) until done_o is seen.
    task automatic run_op(input string tag, input logic [3:0] op, input logic flag,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic saw_rdy;
        @(negedge clk_i);
        valid_i  = 1'b1;
        alu_op_i = op;
        flag_i   = flag;
        a_i      = a;
        b_i      = b;
        @(posedge clk_i);
        @(negedge clk_i);
        a_i     = ~a;
        b_i     = ~b;
        flag_i  = ~flag;
        lat     = 0;
        saw_rdy = 1'b0;
        while (!done_o && lat < 100) begin
            if (ready_o) saw_rdy = 1'b1;
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result_o, exp_res);
        if (exp_lat > 0) check({tag, "_busy_rdy"}, {31'd0, saw_rdy}, 32'd0);
        @(negedge clk_i);
        check({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        alu_op_i = 4'd0;
        flag_i   = 1'b0;
        a_i      = 32'd0;
        b_i      = 32'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        rst_i = 1'b0;

        // Base ops
        run_op("sub",   4'b0000, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("add",   4'b0000, 1'b0, 32'd5, 32'd7, 32'h0000_000C, 0);
        run_op("sra",   4'b0101, 1'b1, 32'h8000_0000, 32'h24, 32'hF800_0000, 0);
        run_op("srl",   4'b0101, 1'b0, 32'h8000_0000, 32'h24, 32'h0800_0000, 0);
        run_op("sll",   4'b0001, 1'b0, 32'h0000_0003, 32'h21, 32'h0000_0006, 0);
        run_op("slt",   4'b0010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
        run_op("sltu",  4'b0011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        run_op("xor",   4'b0100, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 0);
        run_op("or",    4'b0110, 1'b0, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 0);
        run_op("and",   4'b0111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);

        // Back-to-back base ops: one accept per cycle, done pulses on consecutive cycles
        @(negedge clk_i);
        valid_i = 1'b1; alu_op_i = 4'b0000; flag_i = 1'b0; a_i = 32'd10; b_i = 32'd20;
        @(posedge clk_i);
        @(negedge clk_i);
        check("b2b_done1", {31'd0, done_o}, 32'd1);
        check("b2b_res1", result_o, 32'd30);
        check("b2b_rdy", {31'd0, ready_o}, 32'd1);
        flag_i = 1'b1; a_i = 32'd3; b_i = 32'd4;
        @(posedge clk_i);
        @(negedge clk_i);
        check("b2b_done2", {31'd0, done_o}, 32'd1);
        check("b2b_res2", result_o, 32'hFFFF_FFFF);
        valid_i = 1'b0;
        @(negedge clk_i);
        check("b2b_idle", {31'd0, done_o}, 32'd0);

        // Multiply
        run_op("mul",    4'b1000, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 34);
        run_op("mulh",   4'b1001, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34);
        run_op("mulhsu", 4'b1010, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34);
        run_op("mulhu",  4'b1011, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 34);

        // Divide
        run_op("div",    4'b1100, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem",    4'b1110, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("divu",   4'b1101, 1'b0, 32'd100, 32'd7, 32'd14, 34);
        run_op("ovf_div", 4'b1100, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run_op("ovf_rem", 4'b1110, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        run_op("dz_div",  4'b1100, 1'b0, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 34);
        run_op("dz_rem",  4'b1110, 1'b0, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 34);
        run_op("dz_divu", 4'b1101, 1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF, 34);
        run_op("dz_remu", 4'b1111, 1'b0, 32'd7, 32'd0, 32'd7, 34);

        // Reset in the middle of a DIVU
        @(negedge clk_i);
        valid_i = 1'b1; alu_op_i = 4'b1101; flag_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        check("abort_busy", {31'd0, ready_o}, 32'd0);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_ready", {31'd0, ready_o}, 32'd1);
        check("abort_done", {31'd0, done_o}, 32'd0);
        check("abort_result", result_o, 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_op("post_add", 4'b0000, 1'b0, 32'd1, 32'd1, 32'd2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
